// File: rtl/i2c_slave_byte_ctrl_if.sv
// i2c_slave_byte_ctrl_if
//   Bundles the pad-side (scl_i/sda_i, scl_oen/sda_oen) and host-side
//   (config, rx/tx byte handshake, status strobes) signals of the byte-level
//   I2C target.
//   Modports:
//     slave  - the I2C target core
//     master - whatever drives it (host FSM + pad cells, or a testbench)
interface i2c_slave_byte_ctrl_if;
  logic       ena;
  logic [6:0] slv_addr;
  logic       ack_en;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oen;
  logic       sda_oen;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rw;
  logic       busy;
  logic       start_det;
  logic       stop_det;
  logic       nack_det;

  modport slave (
    input  ena, slv_addr, ack_en, scl_i, sda_i, tx_data, tx_valid,
    output scl_oen, sda_oen, rx_data, rx_valid, tx_req, rw, busy,
           start_det, stop_det, nack_det
  );

  modport master (
    output ena, slv_addr, ack_en, scl_i, sda_i, tx_data, tx_valid,
    input  scl_oen, sda_oen, rx_data, rx_valid, tx_req, rw, busy,
           start_det, stop_det, nack_det
  );
endinterface

// File: rtl/i2c_slave_byte_ctrl.sv
// i2c_slave_byte_ctrl
//   Byte-level I2C target. Synchronizes and glitch-filters SCL/SDA, detects
//   START/STOP, matches a 7-bit address, receives write bytes and serves read
//   bytes, stretching SCL while the host supplies each read byte.
//   Ports:
//     clk      - master clock
//     Reset_n  - asynchronous active-low reset (releases the bus at once)
//     bus      - i2c_slave_byte_ctrl_if.slave (pads, config, rx/tx, status)
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | not addressed, bus released, waiting for START
//   S_ADDR     | shifting in address + R/W bit
//   S_ADDR_ACK | driving ACK for a matched address
//   S_WR_DATA  | shifting in a write byte
//   S_WR_ACK   | driving ACK/NACK for a received write byte
//   S_RD_LOAD  | SCL stretched, waiting for the host read byte
//   S_RD_DATA  | driving read byte bits MSB first
//   S_RD_ACK   | sampling the master ACK/NACK of a read byte
module i2c_slave_byte_ctrl #(
  parameter int unsigned FILT_LEN = 3
) (
  input logic                 clk,
  input logic                 Reset_n,
  i2c_slave_byte_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_LOAD, S_RD_DATA, S_RD_ACK
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);

  logic [1:0] r_scl_sync, r_sda_sync;
  logic [3:0] r_scl_cnt, r_sda_cnt;
  logic       r_scl_f, r_sda_f;
  logic       r_scl_q, r_sda_q;

  state_t     r_state;
  logic [7:0] r_sr;
  logic [3:0] r_bit_cnt;
  logic       r_rw;
  logic       r_scl_oen, r_sda_oen;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_tx_req;
  logic       r_start_det, r_stop_det, r_nack_det;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  // Sync + filter: the filtered level follows the synchronized level only
  // after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], bus.scl_i};
      r_sda_sync <= {r_sda_sync[0], bus.sda_i};

      if (r_scl_sync[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CNT_MAX) begin
        r_scl_f   <= r_scl_sync[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end

      if (r_sda_sync[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CNT_MAX) begin
        r_sda_f   <= r_sda_sync[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end

      r_scl_q <= r_scl_f;
      r_sda_q <= r_sda_f;
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_q;
  assign w_scl_fall = ~r_scl_f & r_scl_q;
  // SCL must be high in both samples: when we release a stretched SCL in the
  // same cycle we drive bit 7, SDA can change together with the SCL rise,
  // and that must not read as START/STOP.
  assign w_start = r_scl_f & r_scl_q & ~r_sda_f & r_sda_q;
  assign w_stop  = r_scl_f & r_scl_q & r_sda_f & ~r_sda_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_scl_oen   <= 1'b1;
      r_sda_oen   <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_nack_det  <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_nack_det  <= 1'b0;

      if (!bus.ena) begin
        r_state   <= S_IDLE;
        r_scl_oen <= 1'b1;
        r_sda_oen <= 1'b1;
        r_tx_req  <= 1'b0;
      end else if (w_start) begin
        r_state     <= S_ADDR;
        r_bit_cnt   <= '0;
        r_scl_oen   <= 1'b1;
        r_sda_oen   <= 1'b1;
        r_tx_req    <= 1'b0;
        r_start_det <= 1'b1;
      end else if (w_stop) begin
        r_state    <= S_IDLE;
        r_scl_oen  <= 1'b1;
        r_sda_oen  <= 1'b1;
        r_tx_req   <= 1'b0;
        r_stop_det <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
          end

          S_ADDR: begin
            if (w_scl_rise) begin
              r_sr      <= {r_sr[6:0], r_sda_f};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= '0;
              if (r_sr[7:1] == bus.slv_addr) begin
                r_rw      <= r_sr[0];
                r_sda_oen <= 1'b0;
                r_state   <= S_ADDR_ACK;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end

          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oen <= 1'b1;
              if (r_rw) begin
                r_scl_oen <= 1'b0;
                r_tx_req  <= 1'b1;
                r_state   <= S_RD_LOAD;
              end else begin
                r_state <= S_WR_DATA;
              end
            end
          end

          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_sr      <= {r_sr[6:0], r_sda_f};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt  <= '0;
              r_rx_data  <= r_sr;
              r_rx_valid <= 1'b1;
              r_sda_oen  <= ~bus.ack_en;
              r_state    <= S_WR_ACK;
            end
          end

          S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oen <= 1'b1;
              r_state   <= S_WR_DATA;
            end
          end

          S_RD_LOAD: begin
            if (r_tx_req && bus.tx_valid) begin
              r_sr      <= {bus.tx_data[6:0], 1'b0};
              r_sda_oen <= bus.tx_data[7];
              r_bit_cnt <= 4'd1;
              r_tx_req  <= 1'b0;
              r_scl_oen <= 1'b1;
              r_state   <= S_RD_DATA;
            end
          end

          // r_bit_cnt = number of bits already placed on SDA
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oen <= 1'b1;
                r_bit_cnt <= '0;
                r_state   <= S_RD_ACK;
              end else begin
                r_sda_oen <= r_sr[7];
                r_sr      <= {r_sr[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          S_RD_ACK: begin
            if (w_scl_rise && r_sda_f) begin
              r_nack_det <= 1'b1;
              r_state    <= S_IDLE;
            end else if (w_scl_fall) begin
              r_scl_oen <= 1'b0;
              r_tx_req  <= 1'b1;
              r_state   <= S_RD_LOAD;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.scl_oen   = r_scl_oen;
  assign bus.sda_oen   = r_sda_oen;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.tx_req    = r_tx_req;
  assign bus.rw        = r_rw;
  // "Addressed" means past a matching address, so ADDR itself is not busy.
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_ADDR);
  assign bus.start_det = r_start_det;
  assign bus.stop_det  = r_stop_det;
  assign bus.nack_det  = r_nack_det;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// tb_i2c_slave_byte_ctrl
//   Bit-banged I2C master plus host model around i2c_slave_byte_ctrl.
//   Expected events are queued as stimulus is issued; a monitor pops and
//   compares whenever the DUT (or the master's bus sampling) shows an event.
module tb_i2c_slave_byte_ctrl;
  localparam int HALF = 20;

  localparam logic [2:0] K_START = 3'd0;
  localparam logic [2:0] K_STOP  = 3'd1;
  localparam logic [2:0] K_RX    = 3'd2;
  localparam logic [2:0] K_NACK  = 3'd3;
  localparam logic [2:0] K_TXREQ = 3'd4;
  localparam logic [2:0] K_ACK   = 3'd5;
  localparam logic [2:0] K_RD    = 3'd6;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_drv, sda_drv;
  logic obs_valid;
  logic [2:0] obs_kind;
  logic [7:0] obs_data;
  logic host_en;
  logic txreq_q = 1'b0;
  logic sda_pulled, busy_seen;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_start_seen = 0;
  int   n_stop_seen = 0;

  ev_t        exp_q[$];
  logic [7:0] host_q[$];

  i2c_slave_byte_ctrl_if bus ();

  i2c_slave_byte_ctrl #(.FILT_LEN(3)) dut (
    .clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_i = scl_drv & bus.scl_oen;
  assign bus.sda_i = sda_drv & bus.sda_oen;

  function automatic logic line_scl();
    return scl_drv & bus.scl_oen;
  endfunction

  function automatic logic line_sda();
    return sda_drv & bus.sda_oen;
  endfunction

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_START: return "START";
      K_STOP:  return "STOP";
      K_RX:    return "RX";
      K_NACK:  return "NACK";
      K_TXREQ: return "TXREQ";
      K_ACK:   return "ACKBIT";
      K_RD:    return "RDBYTE";
      default: return "?";
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic seen(input logic [2:0] k, input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got %s data=%02h, expected no event", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        n_err++;
        $display("FAIL event_order: got %s data=%02h, expected %s data=%02h",
                 kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.start_det) begin
      n_start_seen++;
      seen(K_START, 8'h00);
    end
    if (bus.stop_det) begin
      n_stop_seen++;
      seen(K_STOP, 8'h00);
    end
    if (bus.rx_valid) seen(K_RX, bus.rx_data);
    if (bus.nack_det) seen(K_NACK, 8'h00);
    if (bus.tx_req && !txreq_q) seen(K_TXREQ, 8'h00);
    txreq_q = bus.tx_req;
    if (obs_valid) seen(obs_kind, obs_data);
    if (!bus.sda_oen) sda_pulled = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
  end

  // Host: answers tx_req 40 cycles late from host_q
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      wait_clk(1);
      if (bus.tx_req && host_en && host_q.size() > 0) begin
        wait_clk(40);
        check("stretch_hold", {30'd0, bus.scl_oen, line_scl()}, 32'd0);
        bus.tx_data  = host_q.pop_front();
        bus.tx_valid = 1'b1;
        wait_clk(1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
      end
    end
  end

  // Master bit-level tasks
  task automatic observe(input logic [2:0] k, input logic [7:0] d);
    obs_kind  = k;
    obs_data  = d;
    obs_valid = 1'b1;
    wait_clk(1);
    obs_valid = 1'b0;
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_drv = 1'b1;
    while (!line_scl() && t < 4000) begin
      wait_clk(1);
      t++;
    end
    if (!line_scl()) begin
      n_vec++;
      n_err++;
      $display("FAIL scl_release_timeout: scl line low after %0d cycles, expected high", t);
    end
    wait_clk(HALF);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(HALF);
    scl_high();
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl_drv = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl_high();
    sda_drv = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b;
    wait_clk(HALF);
    scl_high();
    scl_drv = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_drv = 1'b1;
    wait_clk(HALF);
    scl_high();
    a = line_sda();
    observe(K_ACK, {7'd0, a});
    scl_drv = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic recv_byte(input logic nack);
    logic [7:0] b;
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1;
      wait_clk(HALF);
      scl_high();
      b[i] = line_sda();
      scl_drv = 1'b0;
      wait_clk(HALF);
    end
    observe(K_RD, b);
    write_bit(nack);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n        = 1'b0;
    scl_drv      = 1'b1;
    sda_drv      = 1'b1;
    obs_valid    = 1'b0;
    obs_kind     = 3'd0;
    obs_data     = 8'h00;
    host_en      = 1'b1;
    sda_pulled   = 1'b0;
    busy_seen    = 1'b0;
    bus.ena      = 1'b1;
    bus.slv_addr = 7'h50;
    bus.ack_en   = 1'b1;
    wait_clk(5);
    check("reset_oen", {30'd0, bus.scl_oen, bus.sda_oen}, 32'd3);
    check("reset_outs", {17'd0, bus.rx_valid, bus.tx_req, bus.rw, bus.busy, bus.start_det,
                         bus.stop_det, bus.nack_det, bus.rx_data}, 32'd0);
    rst_n = 1'b1;
    wait_clk(20);

    // Write 0xA0, 0x3C, 0xFF
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h00);
    send_byte(8'hA0);
    check("wr_busy", {31'd0, bus.busy}, 32'd1);
    check("wr_rw", {31'd0, bus.rw}, 32'd0);
    expect_ev(K_RX, 8'h3C);
    expect_ev(K_ACK, 8'h00);
    send_byte(8'h3C);
    expect_ev(K_RX, 8'hFF);
    expect_ev(K_ACK, 8'h00);
    send_byte(8'hFF);
    expect_ev(K_STOP, 8'h00);
    i2c_stop();
    wait_clk(20);
    check("wr_busy_after_stop", {31'd0, bus.busy}, 32'd0);

    // Address mismatch 0x51
    sda_pulled = 1'b0;
    busy_seen  = 1'b0;
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h01);
    send_byte(8'hA2);
    expect_ev(K_STOP, 8'h00);
    i2c_stop();
    wait_clk(20);
    check("mismatch_sda_pulled", {31'd0, sda_pulled}, 32'd0);
    check("mismatch_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Read 0x96 (ACK) then 0x01 (NACK)
    host_q.push_back(8'h96);
    host_q.push_back(8'h01);
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h00);
    expect_ev(K_TXREQ, 8'h00);
    send_byte(8'hA1);
    check("rd_rw", {31'd0, bus.rw}, 32'd1);
    expect_ev(K_RD, 8'h96);
    expect_ev(K_TXREQ, 8'h00);
    recv_byte(1'b0);
    expect_ev(K_RD, 8'h01);
    expect_ev(K_NACK, 8'h00);
    recv_byte(1'b1);
    wait_clk(10);
    check("rd_busy_after_nack", {31'd0, bus.busy}, 32'd0);
    expect_ev(K_STOP, 8'h00);
    i2c_stop();
    wait_clk(20);

    // Write with ack_en=0
    bus.ack_en = 1'b0;
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h00);
    send_byte(8'hA0);
    expect_ev(K_RX, 8'h55);
    expect_ev(K_ACK, 8'h01);
    send_byte(8'h55);
    expect_ev(K_STOP, 8'h00);
    i2c_stop();
    bus.ack_en = 1'b1;
    wait_clk(20);

    // Repeated START after 4 data bits, then read
    host_q.push_back(8'h5A);
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h00);
    send_byte(8'hA0);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h00);
    expect_ev(K_TXREQ, 8'h00);
    send_byte(8'hA1);
    check("rs_rw", {31'd0, bus.rw}, 32'd1);
    expect_ev(K_RD, 8'h5A);
    expect_ev(K_NACK, 8'h00);
    recv_byte(1'b1);
    expect_ev(K_STOP, 8'h00);
    i2c_stop();
    wait_clk(20);

    // 1-cycle SDA glitch while SCL high
    t = n_start_seen + n_stop_seen;
    sda_drv = 1'b0;
    wait_clk(1);
    sda_drv = 1'b1;
    wait_clk(30);
    check("glitch_no_start_stop", n_start_seen + n_stop_seen - t, 32'd0);

    // Reset during stretch
    host_en = 1'b0;
    expect_ev(K_START, 8'h00);
    i2c_start();
    expect_ev(K_ACK, 8'h00);
    expect_ev(K_TXREQ, 8'h00);
    send_byte(8'hA1);
    t = 0;
    while (!bus.tx_req && t < 200) begin
      wait_clk(1);
      t++;
    end
    check("rst_pre_txreq", {31'd0, bus.tx_req}, 32'd1);
    check("rst_pre_stretch", {31'd0, bus.scl_oen}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_oen", {30'd0, bus.scl_oen, bus.sda_oen}, 32'd3);
    check("rst_async_txreq", {31'd0, bus.tx_req}, 32'd0);
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(50);

    check("exp_queue_empty", exp_q.size(), 32'd0);
    check("host_queue_empty", host_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
